// File: rtl/laundry_pkg.sv
// Shared types and defaults for the laundromat water-inlet arbiter.
package laundry_pkg;

   localparam int DEF_NUM_MACHINES    = 4;
   localparam int DEF_GUARD_CYCLES    = 2;
   localparam int DEF_MAX_FILL_CYCLES = 200;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GUARD = 2'd2
   } arb_state_e;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/laundry_water_arbiter_picker.sv
// Combinational round-robin picker: first eligible index strictly after the
// pointer, wrapping around, so the last winner has the lowest priority.
module rr_priority_picker
   import laundry_pkg::*;
#(
   parameter int NUM_MACHINES = DEF_NUM_MACHINES,
   localparam int ID_W = id_width(NUM_MACHINES)
) (
   input  logic [NUM_MACHINES-1:0] i_elig,
   input  logic [ID_W-1:0]         i_ptr,
   output logic [ID_W-1:0]         o_winner,
   output logic                    o_valid
);

   int w_idx;

   // Scan from the farthest offset down so the nearest eligible index wins.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = 0;
      for (int k = NUM_MACHINES; k >= 1; k--) begin
         w_idx = (int'(i_ptr) + k) % NUM_MACHINES;
         if (i_elig[ID_W'(w_idx)]) begin
            o_winner = ID_W'(w_idx);
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/laundry_water_arbiter.sv
// Shares one mains inlet valve among NUM_MACHINES washers with a closed-valve
// guard between grants. Optional fill timeout: define WATER_TIMEOUT_EN.
//   state    | meaning
//   ST_IDLE  | valve closed, arbitrate eligible requests (held while stop)
//   ST_GRANT | valve open for machine gnt_id until req drops, stop or timeout
//   ST_GUARD | valve closed dead time, GUARD_CYCLES long
module laundry_water_arbiter
   import laundry_pkg::*;
#(
   parameter int NUM_MACHINES    = DEF_NUM_MACHINES,
   parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
   parameter int MAX_FILL_CYCLES = DEF_MAX_FILL_CYCLES,
   localparam int ID_W = id_width(NUM_MACHINES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stop,
   input  logic [NUM_MACHINES-1:0] req,
   input  logic [NUM_MACHINES-1:0] hot_req,
   input  logic [NUM_MACHINES-1:0] tmo_clr,
   output logic [NUM_MACHINES-1:0] gnt,
   output logic [ID_W-1:0]         gnt_id,
   output logic                    valve_open,
   output logic                    hot_sel,
   output logic                    busy,
   output logic [NUM_MACHINES-1:0] tmo_flag
);

   localparam int GW = id_width(GUARD_CYCLES);
   localparam int FW = id_width(MAX_FILL_CYCLES);

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   logic [ID_W-1:0]         r_gnt_id;
   logic [ID_W-1:0]         r_rr_ptr;
   logic [ID_W-1:0]         w_winner;
   logic                    w_valid;
   logic                    r_hot;
   logic [GW-1:0]           r_guard_cnt;
   logic [FW-1:0]           r_fill_cnt;
   logic [NUM_MACHINES-1:0] w_elig;
   logic                    w_req_cur;
   logic                    w_fill_tc;
   logic                    w_force;
   logic                    w_start;
   logic                    w_release;

   assign w_req_cur = req[r_gnt_id];
   assign w_fill_tc = (r_fill_cnt == FW'(MAX_FILL_CYCLES - 1));

`ifdef WATER_TIMEOUT_EN
   logic [NUM_MACHINES-1:0] r_blocked;
   logic [NUM_MACHINES-1:0] r_tmo_flag;

   assign w_force  = (r_state == ST_GRANT) && !stop && w_req_cur && w_fill_tc;
   assign w_elig   = req & ~r_blocked;
   assign tmo_flag = r_tmo_flag;

   // A forced-out machine stays blocked until it drops req; a new timeout beats tmo_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blocked  <= '0;
         r_tmo_flag <= '0;
      end else begin
         r_blocked  <= r_blocked & req;
         r_tmo_flag <= r_tmo_flag & ~tmo_clr;
         if (w_force) begin
            r_blocked[r_gnt_id]  <= 1'b1;
            r_tmo_flag[r_gnt_id] <= 1'b1;
         end
      end
   end
`else
   logic w_unused;

   assign w_force  = 1'b0;
   assign w_elig   = req;
   assign tmo_flag = '0;
   assign w_unused = ^{tmo_clr, w_fill_tc};
`endif

   rr_priority_picker #(
      .NUM_MACHINES(NUM_MACHINES)
   ) u_picker (
      .i_elig   (w_elig),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_start   = (r_state == ST_IDLE) && !stop && w_valid;
   assign w_release = (r_state == ST_GRANT) && (stop || !w_req_cur || w_force);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_state_nxt = ST_GRANT;
         ST_GRANT: if (w_release) w_state_nxt = ST_GUARD;
         ST_GUARD: if (r_guard_cnt == '0) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt_id    <= '0;
         r_rr_ptr    <= ID_W'(NUM_MACHINES - 1);
         r_hot       <= 1'b0;
         r_fill_cnt  <= '0;
         r_guard_cnt <= '0;
      end else begin
         if (w_start) begin
            r_gnt_id   <= w_winner;
            r_rr_ptr   <= w_winner;
            r_hot      <= hot_req[w_winner];
            r_fill_cnt <= '0;
         end else if (r_state == ST_GRANT && !w_fill_tc) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
         end
         if (w_release)
            r_guard_cnt <= GW'(GUARD_CYCLES - 1);
         else if (r_state == ST_GUARD && r_guard_cnt != '0)
            r_guard_cnt <= r_guard_cnt - 1'b1;
      end
   end

   always_comb begin
      gnt        = '0;
      valve_open = 1'b0;
      hot_sel    = 1'b0;
      busy       = (r_state != ST_IDLE);
      gnt_id     = r_gnt_id;
      if (r_state == ST_GRANT) begin
         gnt[r_gnt_id] = 1'b1;
         valve_open    = 1'b1;
         hot_sel       = r_hot;
      end
   end

endmodule

// File: tb/tb_laundry_water_arbiter.sv
// Directed bench for laundry_water_arbiter; expected grants are queued when
// requests are driven and popped when the grant appears.
module tb_laundry_water_arbiter;

   localparam int N = 4;
`ifdef WATER_TIMEOUT_EN
   localparam int         MAXF     = 20;
   localparam int         EXP_FILL = 20;
   localparam logic [3:0] EXP_TMO  = 4'b0001;
   localparam logic [3:0] EXP_HELD = 4'b0000;
`else
   localparam int         MAXF     = 200;
   localparam int         EXP_FILL = 50;
   localparam logic [3:0] EXP_TMO  = 4'b0000;
   localparam logic [3:0] EXP_HELD = 4'b0001;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       stop;
   logic [3:0] req;
   logic [3:0] hot_req;
   logic [3:0] tmo_clr;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       valve_open;
   logic       hot_sel;
   logic       busy;
   logic [3:0] tmo_flag;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int multihot = 0;
   int valve_vio = 0;

   always #5 clk = ~clk;

   laundry_water_arbiter #(
      .NUM_MACHINES(N),
      .GUARD_CYCLES(2),
      .MAX_FILL_CYCLES(MAXF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stop       (stop),
      .req        (req),
      .hot_req    (hot_req),
      .tmo_clr    (tmo_clr),
      .gnt        (gnt),
      .gnt_id     (gnt_id),
      .valve_open (valve_open),
      .hot_sel    (hot_sel),
      .busy       (busy),
      .tmo_flag   (tmo_flag)
   );

   always @(negedge clk) begin
      if (!$onehot0(gnt)) multihot++;
      if (valve_open !== (|gnt)) valve_vio++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_gnt(input string tag);
      int n = 0;
      while (gnt === 4'b0000 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_grant_seen"}, 32'(gnt !== 4'b0000), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle_seen"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int e;
      int n_open;
      int closed;
      int stop_gnts;
      int n_fill;

      rst = 1'b1; stop = 1'b0; req = '0; hot_req = '0; tmo_clr = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_valve", valve_open, 0);
      chk("rst_hot", hot_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tmo", tmo_flag, 0);
      rst = 1'b0;
      @(negedge clk);

      // single requester, 10-cycle fill, then 2-cycle guard
      exp_q.push_back(4'b0100);
      req = 4'b0100;
      @(negedge clk);
      chk("t1_gnt", gnt, exp_q.pop_front());
      chk("t1_gnt_id", gnt_id, 2);
      chk("t1_busy", busy, 1);
      n_open = 1;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         if (valve_open) n_open++;
      end
      req = 4'b0000;
      chk("t1_open_cycles", n_open, 10);
      @(negedge clk);
      chk("t1_guard1", {busy, valve_open}, 2'b10);
      @(negedge clk);
      chk("t1_guard2", {busy, valve_open}, 2'b10);
      @(negedge clk);
      chk("t1_idle", busy, 0);

      // all four requesting: order 0,1,2,3 with a 3-cycle closed gap
      do_reset();
      for (int k = 0; k < 4; k++) exp_q.push_back(k);
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_gnt("t2");
         e = exp_q.pop_front();
         chk("t2_order", gnt_id, e);
         chk("t2_gnt", gnt, 32'd1 << e);
         repeat (4) @(negedge clk);
         req[e[1:0]] = 1'b0;
         if (k < 3) begin
            closed = 0;
            @(negedge clk);
            while (gnt === 4'b0000 && closed < 20) begin
               closed++;
               @(negedge clk);
            end
            chk("t2_gap", closed, 3);
         end
      end
      wait_idle("t2");

      // hot_sel latched at grant, ignores hot_req toggling
      hot_req = 4'b0010;
      req = 4'b0010;
      exp_q.push_back(1);
      wait_gnt("t3");
      chk("t3_gnt_id", gnt_id, exp_q.pop_front());
      chk("t3_hot_grant", hot_sel, 1);
      for (int i = 0; i < 5; i++) begin
         hot_req[1] = ~hot_req[1];
         @(negedge clk);
         chk("t3_hot_hold", hot_sel, 1);
      end
      req = 4'b0000;
      @(negedge clk);
      chk("t3_hot_release", {hot_sel, gnt}, 5'b0);
      wait_idle("t3");
      hot_req = 4'b1011;
      req = 4'b0100;
      exp_q.push_back(2);
      wait_gnt("t3c");
      chk("t3c_gnt_id", gnt_id, exp_q.pop_front());
      chk("t3c_hot_cold", hot_sel, 0);
      req = 4'b0000;
      hot_req = 4'b0000;
      wait_idle("t3c");

      // stop mid-grant of machine 3
      req = 4'b1000;
      exp_q.push_back(3);
      wait_gnt("t4");
      chk("t4_gnt_id", gnt_id, exp_q.pop_front());
      repeat (2) @(negedge clk);
      stop = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      chk("t4_stop_release", {busy, gnt}, 5'b10000);
      stop_gnts = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (gnt !== 4'b0000) stop_gnts++;
      end
      chk("t4_no_gnt_in_stop", stop_gnts, 0);
      chk("t4_idle_in_stop", busy, 0);
      stop = 1'b0;
      exp_q.push_back(0);
      wait_gnt("t4r");
      chk("t4_resume_after_3", gnt_id, exp_q.pop_front());
      req = 4'b0000;
      wait_idle("t4");

      // long fill: timeout build forces release at grant cycle 20
      req = 4'b0001;
      wait_gnt("t5");
      n_fill = 0;
      for (int i = 0; i < 50; i++) begin
         if (gnt[0]) n_fill++;
         @(negedge clk);
      end
      chk("t5_fill_cycles", n_fill, EXP_FILL);
      chk("t5_blocked", gnt, EXP_HELD);
      chk("t5_tmo_flag", tmo_flag, EXP_TMO);
      req = 4'b0000;
      @(negedge clk);
      req = 4'b0001;
      wait_gnt("t5r");
      chk("t5_regrant", gnt, 4'b0001);
      chk("t5_tmo_sticky", tmo_flag, EXP_TMO);
      req = 4'b0000;
      wait_idle("t5");
      tmo_clr = 4'b0001;
      @(negedge clk);
      tmo_clr = 4'b0000;
      chk("t5_tmo_clr", tmo_flag, 0);

      // asynchronous reset mid-grant
      req = 4'b1010;
      exp_q.push_back(1);
      wait_gnt("t6");
      chk("t6_gnt_id", gnt_id, exp_q.pop_front());
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_gnt", gnt, 0);
      chk("t6_async_valve", valve_open, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_tmo", tmo_flag, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      exp_q.push_back(1);
      @(negedge clk);
      wait_gnt("t6r");
      chk("t6_lowest_after_rst", gnt_id, exp_q.pop_front());
      req = 4'b0000;
      wait_idle("t6");

      chk("never_multihot", multihot, 0);
      chk("valve_matches_gnt", valve_vio, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
